// File: rtl/clock_lock_seq.sv
// Lock-qualified reset sequencer with divided clock-enable strobes.
// Runs in the PLL output domain and counts lock losses seen in RUN.
module clock_lock_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 16,
  parameter int RST_HOLD      = 8,
  parameter int CH            = 2,
  parameter int DIV_W         = 8,
  parameter logic [CH*DIV_W-1:0] DIVS = {8'd5, 8'd1},
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pll_locked,
  input  logic             lost_clr,
  output logic             rst_out,
  output logic             locked,
  output logic [CH-1:0]    clk_en,
  output logic             lock_lost,
  output logic [CNT_W-1:0] relock_cnt
);

  localparam int MAXC =
    (STABLE_CYCLES > RST_HOLD) ? STABLE_CYCLES : RST_HOLD;
  localparam int CW = $clog2(MAXC) + 1;
  localparam logic [CW-1:0] ST_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HD_LAST = CW'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    HOLD,
    RUN
  } state_t;

  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   lock_s;

  assign lock_s = sync[SYNC_STAGES-1];

  // Bring the asynchronous PLL lock into the clk domain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
    end
  end

  // Qualification FSM: wait, prove stability, hold reset, run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= WAIT_LOCK;
      cnt        <= '0;
      rst_out    <= 1'b1;
      locked     <= 1'b0;
      lock_lost  <= 1'b0;
      relock_cnt <= '0;
    end else begin
      if (lost_clr) begin
        lock_lost <= 1'b0;
      end
      unique case (state)
        WAIT_LOCK: begin
          cnt <= '0;
          if (lock_s) begin
            state <= STABLE;
          end
        end
        STABLE: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == ST_LAST) begin
            state <= HOLD;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!lock_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == HD_LAST) begin
            state   <= RUN;
            cnt     <= '0;
            rst_out <= 1'b0;
            locked  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          cnt <= '0;
          if (!lock_s) begin
            state     <= WAIT_LOCK;
            rst_out   <= 1'b1;
            locked    <= 1'b0;
            lock_lost <= 1'b1;
            if (relock_cnt != '1) begin
              relock_cnt <= relock_cnt + 1'b1;
            end
          end
        end
        default: begin
          state   <= WAIT_LOCK;
          cnt     <= '0;
          rst_out <= 1'b1;
          locked  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    localparam logic [DIV_W-1:0] DR = DIVS[i*DIV_W +: DIV_W];
    localparam logic [DIV_W-1:0] DL =
      (DR == '0) ? '0 : DR - DIV_W'(1);

    logic [DIV_W-1:0] div_cnt;

    // Per-channel divider, held at zero outside RUN for phase alignment
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        div_cnt <= '0;
      end else if (state != RUN) begin
        div_cnt <= '0;
      end else if (div_cnt == DL) begin
        div_cnt <= '0;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end

    assign clk_en[i] = (state == RUN) && (div_cnt == DL);
  end

endmodule

// File: tb/tb_clock_lock_seq.sv
// Scoreboard bench for clock_lock_seq: stimulus queues expectations,
// a monitor pops and compares them against two DUT instances.
module tb_clock_lock_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       lost_clr;
  logic       probe = 1'b0;

  logic       rst_out, locked, lock_lost;
  logic [1:0] clk_en;
  logic [7:0] relock_cnt;

  logic       rst_out2, locked2, lock_lost2;
  logic [1:0] clk_en2;
  logic [1:0] relock_cnt2;

  always #5 clk = ~clk;

  clock_lock_seq dut (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .lost_clr   (lost_clr),
    .rst_out    (rst_out),
    .locked     (locked),
    .clk_en     (clk_en),
    .lock_lost  (lock_lost),
    .relock_cnt (relock_cnt)
  );

  clock_lock_seq #(.CNT_W(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .lost_clr   (lost_clr),
    .rst_out    (rst_out2),
    .locked     (locked2),
    .clk_en     (clk_en2),
    .lock_lost  (lock_lost2),
    .relock_cnt (relock_cnt2)
  );

  typedef struct {
    logic       ro;
    logic       lk;
    logic [1:0] en;
    bit         chk_en;
    logic       lost;
    logic [7:0] cnt;
    logic [1:0] cnt2;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic push(input logic ro, input logic lk,
                      input logic [1:0] en, input bit chk_en,
                      input logic lost, input logic [7:0] c1,
                      input logic [1:0] c2, input string nm);
    exp_t e;
    e.ro = ro; e.lk = lk; e.en = en; e.chk_en = chk_en;
    e.lost = lost; e.cnt = c1; e.cnt2 = c2; e.nm = nm;
    q.push_back(e);
  endtask

  // Monitor: compare DUT outputs against the oldest expectation
  always @(negedge clk or posedge probe) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      vectors++;
      if (rst_out !== e.ro || locked !== e.lk ||
          (e.chk_en && clk_en !== e.en) ||
          lock_lost !== e.lost || relock_cnt !== e.cnt ||
          rst_out2 !== e.ro || locked2 !== e.lk ||
          (e.chk_en && clk_en2 !== e.en) ||
          lock_lost2 !== e.lost || relock_cnt2 !== e.cnt2) begin
        miscompares++;
        $display("FAIL %s t=%0t: got ro=%b lk=%b en=%b lost=%b cnt=%0d | ro2=%b lk2=%b en2=%b lost2=%b cnt2=%0d ; want ro=%b lk=%b en=%b(chk=%0d) lost=%b cnt=%0d cnt2=%0d",
                 e.nm, $time, rst_out, locked, clk_en, lock_lost,
                 relock_cnt, rst_out2, locked2, clk_en2, lock_lost2,
                 relock_cnt2, e.ro, e.lk, e.en, e.chk_en, e.lost,
                 e.cnt, e.cnt2);
      end
    end
  end

  task automatic edge_chk(input bit p, input bit clr,
                          input logic ro, input logic lk,
                          input logic [1:0] en, input bit chk_en,
                          input logic lost, input logic [7:0] c1,
                          input logic [1:0] c2, input string nm);
    pll_locked = p;
    lost_clr   = clr;
    @(posedge clk);
    #1;
    push(ro, lk, en, chk_en, lost, c1, c2, nm);
  endtask

  // Lock held from edge 1: release after edge 27, then RUN strobes
  task automatic qualify(input int total, input logic lost,
                         input logic [7:0] c1, input logic [1:0] c2);
    logic [1:0] en;
    int r;
    for (int k = 1; k <= total; k++) begin
      en = 2'b00;
      if (k >= 27) begin
        r = k - 27;
        en = {(r % 5 == 4), 1'b1};
      end
      edge_chk(1'b1, 1'b0, k < 27, k >= 27, en, 1'b1,
               lost, c1, c2, "qualify");
    end
  endtask

  // Lock drop in RUN: outputs react on the third edge after sampling
  task automatic lose(input bit clr, input logic lost_p,
                      input logic [7:0] c1p, input logic [1:0] c2p,
                      input logic [7:0] c1, input logic [1:0] c2);
    edge_chk(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0,
             lost_p, c1p, c2p, "loss_j1");
    edge_chk(1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0,
             lost_p, c1p, c2p, "loss_j2");
    edge_chk(1'b0, clr, 1'b1, 1'b0, 2'b00, 1'b1,
             1'b1, c1, c2, "loss_j3");
  endtask

  initial begin
    rst        = 1'b1;
    pll_locked = 1'b0;
    lost_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    push(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'd0, 2'd0, "reset");
    @(posedge clk);
    #1;
    push(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'd0, 2'd0, "reset2");
    rst = 1'b0;

    qualify(41, 1'b0, 8'd0, 2'd0);

    lose(1'b1, 1'b0, 8'd0, 2'd0, 8'd1, 2'd1);
    edge_chk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1,
             1'b0, 8'd1, 2'd1, "lost_clr");

    qualify(32, 1'b0, 8'd1, 2'd1);
    lose(1'b0, 1'b0, 8'd1, 2'd1, 8'd2, 2'd2);
    qualify(32, 1'b1, 8'd2, 2'd2);
    lose(1'b0, 1'b1, 8'd2, 2'd2, 8'd3, 2'd3);
    qualify(32, 1'b1, 8'd3, 2'd3);
    lose(1'b0, 1'b1, 8'd3, 2'd3, 8'd4, 2'd3);
    qualify(32, 1'b1, 8'd4, 2'd3);
    lose(1'b0, 1'b1, 8'd4, 2'd3, 8'd5, 2'd3);
    edge_chk(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b1,
             1'b0, 8'd5, 2'd3, "lost_clr2");

    for (int k = 1; k <= 13; k++)
      edge_chk(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1,
               1'b0, 8'd5, 2'd3, "pre_glitch");
    for (int k = 14; k <= 16; k++)
      edge_chk(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b1,
               1'b0, 8'd5, 2'd3, "glitch");
    qualify(30, 1'b0, 8'd5, 2'd3);

    lose(1'b0, 1'b0, 8'd5, 2'd3, 8'd6, 2'd3);
    qualify(22, 1'b1, 8'd6, 2'd3);

    @(negedge clk);
    #1;
    rst = 1'b1;
    push(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 8'd0, 2'd0, "async_rst");
    #1 probe = 1'b1;
    #1 probe = 1'b0;
    rst = 1'b0;
    qualify(30, 1'b0, 8'd0, 2'd0);

    repeat (3) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
